sha256_ctrl: RTL

Sequencing controller for the SHA-256 core. It accepts 512-bit message blocks as 16 × 32-bit words over a valid/ready handshake and forwards each word to `msg_sch`. It then generates the round index and the load, step and round strobes for rounds 0–63. It also controls hash initialisation, working-variable loading and the per-block hash update, chaining any number of blocks per message.

---
 rtl/sha256_pkg.sv | 39 +++
 rtl/sha256_round_cnt.sv | 30 +++
 rtl/sha256_ctrl.sv | 107 ++++++++++
 3 files changed

// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - shared types and constants for the SHA-256 core
package sha256_pkg;

  localparam int NUM_ROUNDS  = 64;
  localparam int MSG_WORDS   = 16;
  localparam int LAST_LOAD_T = 15;

  typedef logic [5:0] round_idx_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_PREP,
    ST_LOAD,
    ST_COMP,
    ST_UPD,
    ST_DONE
  } sha_ctrl_state_t;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

endpackage

// File: rtl/sha256_round_cnt.sv
// rtl/sha256_round_cnt.sv - 6-bit round counter with clear, enable and terminal flags
module sha256_round_cnt
  import sha256_pkg::*;
#(
  parameter int LOAD_LAST  = LAST_LOAD_T,
  parameter int ROUND_LAST = NUM_ROUNDS - 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  output round_idx_t cnt,
  output logic       t_is_15,
  output logic       t_is_63
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 6'd1;
    end
  end

  assign t_is_15 = (cnt == 6'(LOAD_LAST));
  assign t_is_63 = (cnt == 6'(ROUND_LAST));

endmodule

// File: rtl/sha256_ctrl.sv
// rtl/sha256_ctrl.sv - SHA-256 block sequencing FSM: word intake, round strobes, hash init/update
module sha256_ctrl #(
  parameter int NUM_ROUNDS = 64,
  parameter int MSG_WORDS  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        msg_valid_i,
  output logic        msg_ready_o,
  input  logic [31:0] msg_data_i,
  input  logic        msg_last_i,
  output logic [31:0] sch_M_o,
  output logic        sch_load_o,
  output logic        sch_step_o,
  output logic        round_en_o,
  output logic [5:0]  round_t_o,
  output logic        init_hash_o,
  output logic        load_work_o,
  output logic        update_hash_o,
  output logic        busy_o,
  output logic        done_o
);

  sha256_pkg::sha_ctrl_state_t state, state_n;
  sha256_pkg::round_idx_t      cnt;
  logic                        t_is_15, t_is_63;
  logic                        last_q;
  logic                        cnt_clr, cnt_en;

  // Counter stops at the final round so round_t_o never shows a wrapped index.
  assign cnt_clr = (state == sha256_pkg::ST_PREP);
  assign cnt_en  = round_en_o & ~t_is_63;

  sha256_round_cnt #(
    .LOAD_LAST (MSG_WORDS - 1),
    .ROUND_LAST(NUM_ROUNDS - 1)
  ) u_round_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .cnt    (cnt),
    .t_is_15(t_is_15),
    .t_is_63(t_is_63)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= sha256_pkg::ST_IDLE;
      last_q <= 1'b0;
    end else begin
      state <= state_n;
      if (state == sha256_pkg::ST_INIT) begin
        last_q <= 1'b0;
      end else if (sch_load_o && t_is_15) begin
        last_q <= msg_last_i;
      end
    end
  end

  always_comb begin
    state_n       = state;
    msg_ready_o   = 1'b0;
    sch_load_o    = 1'b0;
    sch_step_o    = 1'b0;
    init_hash_o   = 1'b0;
    load_work_o   = 1'b0;
    update_hash_o = 1'b0;
    done_o        = 1'b0;
    unique case (state)
      sha256_pkg::ST_IDLE: if (start_i) state_n = sha256_pkg::ST_INIT;
      sha256_pkg::ST_INIT: begin
        init_hash_o = 1'b1;
        state_n     = sha256_pkg::ST_PREP;
      end
      sha256_pkg::ST_PREP: begin
        load_work_o = 1'b1;
        state_n     = sha256_pkg::ST_LOAD;
      end
      sha256_pkg::ST_LOAD: begin
        msg_ready_o = 1'b1;
        sch_load_o  = msg_valid_i;
        if (msg_valid_i && t_is_15) state_n = sha256_pkg::ST_COMP;
      end
      sha256_pkg::ST_COMP: begin
        sch_step_o = 1'b1;
        if (t_is_63) state_n = sha256_pkg::ST_UPD;
      end
      sha256_pkg::ST_UPD: begin
        update_hash_o = 1'b1;
        state_n       = last_q ? sha256_pkg::ST_DONE : sha256_pkg::ST_PREP;
      end
      sha256_pkg::ST_DONE: begin
        done_o  = 1'b1;
        state_n = sha256_pkg::ST_IDLE;
      end
      default: state_n = sha256_pkg::ST_IDLE;
    endcase
  end

  assign round_en_o = sch_load_o | sch_step_o;
  assign round_t_o  = cnt;
  assign busy_o     = (state != sha256_pkg::ST_IDLE);
  assign sch_M_o    = msg_data_i;

endmodule
